// File: rtl/spike_encoder_pkg.sv
// Shared types and default sizes for the temporal spike encoder.
// A value of all ones (MAX) means the line never fires in that window.
package spike_encoder_pkg;

  localparam int NUM_SPIKES_DEF = 4;
  localparam int VBITS_DEF      = 3;
  localparam int GAP_CYCLES_DEF = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WINDOW = 2'd1,
    GAP    = 2'd2
  } enc_state_t;

endpackage

// File: rtl/spike_encoder_time_cmp.sv
// Per-line comparator: decides whether a line is high at window time t.
// The pulse/step selection is fixed by STEP_MODE.
module spike_time_cmp #(
  parameter int VBITS     = 3,
  parameter int STEP_MODE = 0
) (
  input  logic [VBITS-1:0] t,
  input  logic [VBITS-1:0] value,
  output logic             fire
);

  localparam logic [VBITS-1:0] MAX_V = {VBITS{1'b1}};

  always_comb begin
    fire = 1'b0;
    if (value != MAX_V) begin
      if (STEP_MODE == 0) begin
        fire = (t == value);
      end else begin
        // Step lines all fall together in the last window cycle.
        fire = (value <= t) && (t != MAX_V);
      end
    end
  end

endmodule

// File: rtl/spike_encoder.sv
// Race-logic input encoder: one value vector per gamma cycle becomes
// spike times on the neuron spike bus, followed by a quiet gap.
module spike_encoder
  import spike_encoder_pkg::*;
#(
  parameter int NUM_SPIKES = NUM_SPIKES_DEF,
  parameter int VBITS      = VBITS_DEF,
  parameter int GAP_CYCLES = GAP_CYCLES_DEF,
  parameter int STEP_MODE  = 0
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  input  logic [NUM_SPIKES*VBITS-1:0] in_values,
  output logic                        in_ready,
  output logic [NUM_SPIKES-1:0]       spikes_out,
  output logic                        gamma_start,
  output logic                        gamma_end,
  output logic                        busy,
  output enc_state_t                  dbg_state
);

  // Handshake: a vector transfers on a rising edge where in_valid && in_ready;
  // in_ready is high only in IDLE and nothing is buffered while busy.

  localparam logic [VBITS-1:0] MAX_V    = {VBITS{1'b1}};
  localparam logic [3:0]       GAP_LAST = 4'(GAP_CYCLES - 1);

  enc_state_t                  state_q, state_n;
  logic [VBITS-1:0]            t_q, t_n;
  logic [3:0]                  g_q, g_n;
  logic [NUM_SPIKES*VBITS-1:0] vals_q, vals_n;
  logic [NUM_SPIKES-1:0]       fire_n;

  assign in_ready  = (state_q == IDLE);
  assign dbg_state = state_q;

  always_comb begin
    state_n = state_q;
    t_n     = t_q;
    g_n     = g_q;
    vals_n  = vals_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          vals_n  = in_values;
          t_n     = '0;
          state_n = WINDOW;
        end
      end
      WINDOW: begin
        if (t_q == MAX_V) begin
          g_n     = '0;
          state_n = GAP;
        end else begin
          t_n = t_q + 1'b1;
        end
      end
      GAP: begin
        if (g_q == GAP_LAST) begin
          state_n = IDLE;
        end else begin
          g_n = g_q + 4'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Comparators look at next-cycle time so the spike bus can be registered.
  for (genvar i = 0; i < NUM_SPIKES; i++) begin : g_line
    spike_time_cmp #(
      .VBITS     (VBITS),
      .STEP_MODE (STEP_MODE)
    ) u_cmp (
      .t     (t_n),
      .value (vals_n[i*VBITS +: VBITS]),
      .fire  (fire_n[i])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      t_q         <= '0;
      g_q         <= '0;
      vals_q      <= '0;
      spikes_out  <= '0;
      gamma_start <= 1'b0;
      gamma_end   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state_q     <= state_n;
      t_q         <= t_n;
      g_q         <= g_n;
      vals_q      <= vals_n;
      spikes_out  <= (state_n == WINDOW) ? fire_n : '0;
      gamma_start <= (state_n == WINDOW) && (t_n == '0);
      gamma_end   <= (state_n == GAP) && (g_n == GAP_LAST);
      busy        <= (state_n != IDLE);
    end
  end

endmodule

// File: tb/tb_spike_encoder.sv
// Bench for spike_encoder: pulse-mode and step-mode instances share the
// same stimulus; expected spike vectors are queued per window cycle.
module tb_spike_encoder;
  import spike_encoder_pkg::*;

  localparam int NS = 4;
  localparam int VB = 3;
  localparam int VW = NS * VB;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic [VW-1:0] in_values = '0;

  logic          in_ready0, in_ready1;
  logic [NS-1:0] spikes0, spikes1;
  logic          gstart0, gstart1, gend0, gend1, busy0, busy1;
  enc_state_t    dbg0, dbg1;

  int n_checks = 0;
  int n_pass   = 0;

  logic [NS-1:0] exp_q[$];
  logic [NS-1:0] exp_step_q[$];

  spike_encoder #(.NUM_SPIKES(NS), .VBITS(VB), .GAP_CYCLES(2), .STEP_MODE(0)) dut0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_values(in_values),
    .in_ready(in_ready0), .spikes_out(spikes0), .gamma_start(gstart0),
    .gamma_end(gend0), .busy(busy0), .dbg_state(dbg0)
  );

  spike_encoder #(.NUM_SPIKES(NS), .VBITS(VB), .GAP_CYCLES(2), .STEP_MODE(1)) dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_values(in_values),
    .in_ready(in_ready1), .spikes_out(spikes1), .gamma_start(gstart1),
    .gamma_end(gend1), .busy(busy1), .dbg_state(dbg1)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [VW-1:0] pack4(input int v3, input int v2, input int v1, input int v0);
    return {3'(v3), 3'(v2), 3'(v1), 3'(v0)};
  endfunction

  // Spike-time rule: fire at t == value, never for value 7; step lines hold until t=7.
  function automatic logic [NS-1:0] model(input logic [VW-1:0] v, input int t, input bit step);
    logic [NS-1:0] r;
    r = '0;
    for (int i = 0; i < NS; i++) begin
      int val;
      val = int'(v[i*VB +: VB]);
      if (val != 7) r[i] = step ? (val <= t && t != 7) : (t == val);
    end
    return r;
  endfunction

  task automatic load_model(input logic [VW-1:0] v);
    for (int t = 0; t < 8; t++) begin
      exp_q.push_back(model(v, t, 1'b0));
      exp_step_q.push_back(model(v, t, 1'b1));
    end
    for (int g = 0; g < 2; g++) begin
      exp_q.push_back('0);
      exp_step_q.push_back('0);
    end
  endtask

  task automatic send_vector(input logic [VW-1:0] v);
    int n;
    n = 0;
    in_valid  = 1'b1;
    in_values = v;
    while (!in_ready0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("accept_timeout", 32'(0), 32'(1));
  endtask

  // Checks cycles c+1..c+11 after the accepting edge of cycle c.
  task automatic check_window(input bit hold, input logic [VW-1:0] next_vals, input bit toggle);
    logic [NS-1:0] e0, e1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 1) begin
        if (hold) in_values = next_vals;
        else in_valid = 1'b0;
      end
      if (toggle) in_values = VW'($urandom);
      e0 = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
      e1 = (exp_step_q.size() > 0) ? exp_step_q.pop_front() : '1;
      check($sformatf("spikes_pulse_k%0d", k), 32'(spikes0), 32'(e0));
      check($sformatf("spikes_step_k%0d", k), 32'(spikes1), 32'(e1));
      check($sformatf("gamma_start_k%0d", k), 32'(gstart0), 32'(k == 1));
      check($sformatf("gamma_end_k%0d", k), 32'(gend0), 32'(k == 10));
      check($sformatf("busy_k%0d", k), 32'(busy0), 32'(1));
      check($sformatf("in_ready_k%0d", k), 32'(in_ready0), 32'(0));
      check($sformatf("step_busy_k%0d", k), 32'(busy1), 32'(1));
    end
    @(negedge clk);
    check("in_ready_after", 32'(in_ready0), 32'(1));
    check("busy_after", 32'(busy0), 32'(0));
    check("gamma_end_after", 32'(gend0), 32'(0));
    check("state_after", 32'(dbg0), 32'(IDLE));
  endtask

  initial begin
    logic [VW-1:0] v;

    // reset state
    repeat (3) @(negedge clk);
    check("rst_spikes", 32'(spikes0), 32'(0));
    check("rst_busy", 32'(busy0), 32'(0));
    check("rst_gstart", 32'(gstart0), 32'(0));
    check("rst_gend", 32'(gend0), 32'(0));
    check("rst_state", 32'(dbg0), 32'(IDLE));
    reset = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready0), 32'(1));

    // values {0,3,7,5}: hand-computed pulse and step traces
    exp_q      = '{4'b0001, 4'b0000, 4'b0000, 4'b0010, 4'b0000, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    exp_step_q = '{4'b0001, 4'b0001, 4'b0001, 4'b0011, 4'b0011, 4'b1011, 4'b1011, 4'b0000, 4'b0000, 4'b0000};
    send_vector(pack4(5, 7, 3, 0));
    check_window(1'b0, '0, 1'b0);

    // back-to-back with in_valid held high
    load_model(pack4(1, 1, 1, 1));
    send_vector(pack4(1, 1, 1, 1));
    check_window(1'b1, pack4(2, 2, 2, 2), 1'b0);
    load_model(pack4(2, 2, 2, 2));
    check_window(1'b0, '0, 1'b0);

    // all MAX: no spikes, gamma pulses still present
    load_model(pack4(7, 7, 7, 7));
    send_vector(pack4(7, 7, 7, 7));
    check_window(1'b0, '0, 1'b0);

    // all zero: every line fires with gamma_start
    load_model(pack4(0, 0, 0, 0));
    send_vector(pack4(0, 0, 0, 0));
    check_window(1'b0, '0, 1'b0);

    // reset at t=3 of a window with {0,3,2,1}
    send_vector(pack4(1, 2, 3, 0));
    @(negedge clk);
    in_valid = 1'b0;
    check("mid_t0", 32'(spikes0), 32'(4'b0001));
    @(negedge clk);
    check("mid_t1", 32'(spikes0), 32'(4'b1000));
    @(negedge clk);
    check("mid_t2", 32'(spikes0), 32'(4'b0100));
    @(negedge clk);
    check("mid_t3", 32'(spikes0), 32'(4'b0010));
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid_rst_state", 32'(dbg0), 32'(IDLE));
    check("mid_rst_spikes", 32'(spikes0), 32'(0));
    check("mid_rst_step_spikes", 32'(spikes1), 32'(0));
    check("mid_rst_busy", 32'(busy0), 32'(0));
    check("mid_rst_gend", 32'(gend0), 32'(0));
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("post_rst_gend", 32'(gend0), 32'(0));
      check("post_rst_ready", 32'(in_ready0), 32'(1));
    end
    load_model(pack4(2, 2, 2, 2));
    send_vector(pack4(2, 2, 2, 2));
    check_window(1'b0, '0, 1'b0);

    // in_values scrambled after the handshake
    v = pack4(4, 6, 1, 3);
    load_model(v);
    send_vector(v);
    check_window(1'b0, '0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1);
  end

endmodule
